// File: rtl/axi4_pkg.sv
// Shared response codes and FSM state encoding for the AXI4 RAM responder.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

endpackage

// File: rtl/axi4_ram_responder_if.sv
// AXI4 slave-side bus bundle (AW/W/B/AR/R) between the interconnect and the RAM responder.
interface axi4_ram_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // Every channel transfers on a rising clock edge where valid && ready; once valid is
    // raised the source holds its payload stable until that edge.
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi4_ram_array.sv
// Word-organised RAM with per-byte write enables and a one-cycle registered read; no reset.
module axi4_ram_array #(
    parameter int WORDS      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    re,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // rdata only moves on re, so it doubles as the held R-channel payload during stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 slave RAM responder: one transaction at a time, INCR bursts, byte strobes, SLVERR on
// out-of-range beats or bad WLAST framing.
module axi4_ram_responder
    import axi4_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000_0000,
    parameter int                    MEM_WORDS  = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi4_ram_responder_if.slave  s,
    output state_t               dbg_state
);

    localparam int RAM_AW = $clog2(MEM_WORDS);

    typedef logic [ADDR_WIDTH-1:0] idx_t;

    state_t              state, state_nx;
    logic                last_read;
    logic [ID_WIDTH-1:0] bid_q, rid_q;
    logic [7:0]          len_q;
    logic [8:0]          cnt_q;
    idx_t                idx_q;
    logic                w_err_q, r_err_q;

    idx_t                aw_idx, ar_idx, idx_inc;
    logic                grant_w, grant_r, is_last, w_live, w_beat_err;
    logic                ram_re, ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0] ram_q;

    function automatic logic in_range(input idx_t i);
        return i < idx_t'(MEM_WORDS);
    endfunction

    // Addresses below BASE_ADDR wrap to huge indices and therefore land out of range.
    assign aw_idx  = (s.awaddr - BASE_ADDR) >> 2;
    assign ar_idx  = (s.araddr - BASE_ADDR) >> 2;
    assign idx_inc = idx_q + idx_t'(1);

    assign grant_w = s.awvalid && (!s.arvalid || last_read);
    assign grant_r = s.arvalid && (!s.awvalid || !last_read);

    assign is_last    = (cnt_q == {1'b0, len_q});
    assign w_live     = (cnt_q <= {1'b0, len_q});
    assign w_beat_err = (w_live && !in_range(idx_q)) || (s.wlast && !is_last);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        s.awready = 1'b0;
        s.arready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        s.rvalid  = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = idx_q[RAM_AW-1:0];
        case (state)
            ST_IDLE: begin
                s.awready = grant_w;
                s.arready = grant_r;
                if (grant_w) begin
                    state_nx = ST_WDATA;
                end else if (grant_r) begin
                    state_nx = ST_RDATA;
                    ram_re   = 1'b1;
                    ram_addr = ar_idx[RAM_AW-1:0];
                end
            end
            ST_WDATA: begin
                s.wready = 1'b1;
                ram_we   = s.wvalid && w_live && in_range(idx_q);
                if (s.wvalid && s.wlast) state_nx = ST_WRESP;
            end
            ST_WRESP: begin
                s.bvalid = 1'b1;
                if (s.bready) state_nx = ST_IDLE;
            end
            ST_RDATA: begin
                s.rvalid = 1'b1;
                if (s.rready) begin
                    if (is_last) begin
                        state_nx = ST_IDLE;
                    end else begin
                        ram_re   = 1'b1;
                        ram_addr = idx_inc[RAM_AW-1:0];
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_read <= 1'b1;
            bid_q     <= '0;
            rid_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            w_err_q   <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            if (s.awvalid && s.awready) begin
                bid_q     <= s.awid;
                len_q     <= s.awlen;
                cnt_q     <= '0;
                idx_q     <= aw_idx;
                w_err_q   <= 1'b0;
                last_read <= 1'b0;
            end
            if (s.arvalid && s.arready) begin
                rid_q     <= s.arid;
                len_q     <= s.arlen;
                cnt_q     <= '0;
                idx_q     <= ar_idx;
                r_err_q   <= !in_range(ar_idx);
                last_read <= 1'b1;
            end
            // Surplus write beats keep counting (saturating) so late WLAST is still flagged.
            if (state == ST_WDATA && s.wvalid) begin
                w_err_q <= w_err_q | w_beat_err;
                if (cnt_q != 9'h1FF) begin
                    cnt_q <= cnt_q + 9'd1;
                    idx_q <= idx_inc;
                end
            end
            if (state == ST_RDATA && s.rready && !is_last) begin
                cnt_q   <= cnt_q + 9'd1;
                idx_q   <= idx_inc;
                r_err_q <= !in_range(idx_inc);
            end
        end
    end

    assign s.bid   = bid_q;
    assign s.bresp = (state == ST_WRESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s.rid   = rid_q;
    assign s.rdata = (state == ST_RDATA && !r_err_q) ? ram_q : '0;
    assign s.rresp = (state == ST_RDATA && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s.rlast = (state == ST_RDATA) && is_last;

    assign dbg_state = state;

    axi4_ram_array #(
        .WORDS      (MEM_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (RAM_AW)
    ) u_ram (
        .clk   (ACLK),
        .re    (ram_re),
        .we    (ram_we),
        .be    (s.wstrb),
        .addr  (ram_addr),
        .wdata (s.wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed bench for axi4_ram_responder with expected-queue scoreboard and a negedge monitor.
module tb_axi4_ram_responder;
  import axi4_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int RW = IW + DW + 3;
  localparam int BW = IW + 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_ram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();
  state_t dbg_state;

  axi4_ram_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .BASE_ADDR(32'h1000_0000), .MEM_WORDS(1024)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn), .s(bus), .dbg_state(dbg_state)
  );

  logic [RW-1:0] exp_r_q[$];
  logic [BW-1:0] exp_b_q[$];
  logic          exp_g_q[$];
  logic          got_g_q[$];
  logic [31:0]   wq[$];
  int n_checks = 0;
  int n_pass = 0;
  logic both_ready = 1'b0;
  logic stall_q = 1'b0;
  logic [RW-1:0] stall_val;
  logic [RW-1:0] r_cur;
  logic [63:0] rst_vec;

  assign r_cur = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
  assign rst_vec = {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast,
                    bus.rdata, bus.rid, bus.bid, bus.rresp, bus.bresp};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_r(input logic [IW-1:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    exp_r_q.push_back({id, d, resp, last});
  endtask

  // Monitor: pops the scoreboard on every B/R handshake and checks R stability under stall.
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_q <= 1'b0;
    end else begin
      if (bus.awready && bus.arready) both_ready <= 1'b1;
      if (bus.awvalid && bus.awready) got_g_q.push_back(1'b1);
      if (bus.arvalid && bus.arready) got_g_q.push_back(1'b0);
      if (stall_q) begin
        check("r_hold_valid", 64'(bus.rvalid), 64'd1);
        check("r_hold_payload", 64'(r_cur), 64'(stall_val));
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_b_q.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected: got %h expected no response", {bus.bid, bus.bresp});
        end else begin
          check("b_resp", 64'({bus.bid, bus.bresp}), 64'(exp_b_q.pop_front()));
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r_q.size() == 0) begin
          n_checks++;
          $display("FAIL r_unexpected: got %h expected no beat", r_cur);
        end else begin
          check("r_beat", 64'(r_cur), 64'(exp_r_q.pop_front()));
        end
      end
      stall_q <= bus.rvalid && !bus.rready;
      stall_val <= r_cur;
    end
  end

  task automatic write_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] strb, input int last_at, input logic [1:0] exp_resp);
    int n;
    exp_b_q.push_back({id, exp_resp});
    @(posedge aclk); #1;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.awready && n < 200);
    if (!bus.awready) begin n_checks++; $display("FAIL aw_timeout: got no awready expected awready"); end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      bus.wdata = wq[i]; bus.wstrb = strb; bus.wlast = (i + 1 == last_at); bus.wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!bus.wready && n < 200);
      if (!bus.wready) begin n_checks++; $display("FAIL w_timeout: got no wready expected wready"); end
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    n = 0;
    while (exp_b_q.size() != 0 && n < 200) begin @(negedge aclk); n++; end
    if (exp_b_q.size() != 0) begin
      n_checks++;
      $display("FAIL b_timeout: got %0d pending expected 0", exp_b_q.size());
      exp_b_q.delete();
    end
  endtask

  task automatic read_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input bit toggle);
    int n;
    @(posedge aclk); #1;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
    bus.rready = !toggle;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.arready && n < 200);
    if (!bus.arready) begin n_checks++; $display("FAIL ar_timeout: got no arready expected arready"); end
    check("rvalid_in_ar_cycle", 64'(bus.rvalid), 64'd0);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    @(negedge aclk);
    check("rvalid_after_ar", 64'(bus.rvalid), 64'd1);
    n = 0;
    while (exp_r_q.size() != 0 && n < 300) begin
      @(posedge aclk); #1;
      if (toggle) bus.rready = !bus.rready;
      n++;
    end
    if (exp_r_q.size() != 0) begin
      n_checks++;
      $display("FAIL r_timeout: got %0d pending expected 0", exp_r_q.size());
      exp_r_q.delete();
    end
    bus.rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", rst_vec, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    aresetn = 1'b1;

    // single write then read
    wq = '{32'hDEAD_BEEF};
    write_burst(4'd1, 32'h1000_0010, 8'd0, 4'hF, 1, RESP_OKAY);
    push_r(4'd2, 32'hDEAD_BEEF, RESP_OKAY, 1'b1);
    read_burst(4'd2, 32'h1000_0010, 8'd0, 1'b0);

    // 4-beat INCR burst, read back with RREADY toggling
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    write_burst(4'd5, 32'h1000_0100, 8'd3, 4'hF, 4, RESP_OKAY);
    push_r(4'd5, 32'd1, RESP_OKAY, 1'b0);
    push_r(4'd5, 32'd2, RESP_OKAY, 1'b0);
    push_r(4'd5, 32'd3, RESP_OKAY, 1'b0);
    push_r(4'd5, 32'd4, RESP_OKAY, 1'b1);
    read_burst(4'd5, 32'h1000_0100, 8'd3, 1'b1);

    // partial strobes
    wq = '{32'h1122_3344};
    write_burst(4'd3, 32'h1000_0200, 8'd0, 4'hF, 1, RESP_OKAY);
    wq = '{32'hAABB_CCDD};
    write_burst(4'd3, 32'h1000_0200, 8'd0, 4'b0101, 1, RESP_OKAY);
    push_r(4'd4, 32'h11BB_33DD, RESP_OKAY, 1'b1);
    read_burst(4'd4, 32'h1000_0200, 8'd0, 1'b0);

    // range errors at the top of the array
    wq = '{32'hCAFE_F00D, 32'h1234_5678};
    write_burst(4'd6, 32'h1000_0FFC, 8'd1, 4'hF, 2, RESP_SLVERR);
    push_r(4'd6, 32'hCAFE_F00D, RESP_OKAY, 1'b0);
    push_r(4'd6, 32'h0, RESP_SLVERR, 1'b1);
    read_burst(4'd6, 32'h1000_0FFC, 8'd1, 1'b0);

    // early WLAST: in-range beats still land
    wq = '{32'd9, 32'd10};
    write_burst(4'd7, 32'h1000_0300, 8'd3, 4'hF, 2, RESP_SLVERR);
    push_r(4'd7, 32'd9, RESP_OKAY, 1'b0);
    push_r(4'd7, 32'd10, RESP_OKAY, 1'b1);
    read_burst(4'd7, 32'h1000_0300, 8'd1, 1'b1);

    // late WLAST: surplus beat discarded
    wq = '{32'h77, 32'h88};
    write_burst(4'd8, 32'h1000_0400, 8'd0, 4'hF, 2, RESP_SLVERR);
    push_r(4'd8, 32'h77, RESP_OKAY, 1'b1);
    read_burst(4'd8, 32'h1000_0400, 8'd0, 1'b0);

    // below base address
    push_r(4'd9, 32'h0, RESP_SLVERR, 1'b1);
    read_burst(4'd9, 32'h0FFF_FFFC, 8'd0, 1'b0);

    // reset in the middle of a read burst
    push_r(4'd6, 32'd1, RESP_OKAY, 1'b0);
    push_r(4'd6, 32'd2, RESP_OKAY, 1'b0);
    push_r(4'd6, 32'd3, RESP_OKAY, 1'b0);
    push_r(4'd6, 32'd4, RESP_OKAY, 1'b1);
    fork
      read_burst(4'd6, 32'h1000_0100, 8'd3, 1'b1);
      begin
        n = 0;
        while (exp_r_q.size() > 2 && n < 300) begin @(negedge aclk); n++; end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        exp_r_q.delete();
        #1;
        check("midburst_reset_outputs", rst_vec, 64'd0);
        check("midburst_reset_state", 64'(dbg_state), 64'(ST_IDLE));
      end
    join
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("no_beats_after_reset", 64'(bus.rvalid), 64'd0);
    end

    // simultaneous AW/AR twice: write, read, write, read
    got_g_q.delete();
    exp_g_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    wq = '{32'h55};
    push_r(4'd8, 32'hDEAD_BEEF, RESP_OKAY, 1'b1);
    fork
      write_burst(4'd7, 32'h1000_0500, 8'd0, 4'hF, 1, RESP_OKAY);
      read_burst(4'd8, 32'h1000_0010, 8'd0, 1'b0);
    join
    wq = '{32'h66};
    push_r(4'd10, 32'h55, RESP_OKAY, 1'b1);
    fork
      write_burst(4'd9, 32'h1000_0504, 8'd0, 4'hF, 1, RESP_OKAY);
      read_burst(4'd10, 32'h1000_0500, 8'd0, 1'b0);
    join
    check("grant_count", 64'(got_g_q.size()), 64'(exp_g_q.size()));
    for (int i = 0; i < exp_g_q.size() && i < got_g_q.size(); i++) begin
      check("grant_order", 64'(got_g_q[i]), 64'(exp_g_q[i]));
    end

    // RAM contents survive reset
    push_r(4'd11, 32'd1, RESP_OKAY, 1'b0);
    push_r(4'd11, 32'd2, RESP_OKAY, 1'b0);
    push_r(4'd11, 32'd3, RESP_OKAY, 1'b0);
    push_r(4'd11, 32'd4, RESP_OKAY, 1'b1);
    read_burst(4'd11, 32'h1000_0100, 8'd3, 1'b0);

    check("never_both_ready", 64'(both_ready), 64'd0);
    repeat (2) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
